ram_lsu: RTL and testbench
==========================

# ram_lsu

Load/store sequencer that acts as the single initiator on the byte-lane `ram` data memory. It accepts one CPU access at a time (byte, halfword or word; any byte address) and drives the RAM write port (A) and read port (B). Sub-word stores use read-modify-write because the RAM has no byte enables. Load results come back sign- or zero-extended over a valid/ready response channel.

## Interface
- No parameters. Address width is 13 bits and data width is 32 bits, matching `ram`.
- `clk  in  1`: single clock; also clocks both RAM ports.
- `rst_n  in  1`: asynchronous, active-low reset.
- `req_valid  in  1`: access request.
- `req_ready  out  1`: high only in IDLE.
- `req_we  in  1`: 1 = store, 0 = load.
- `req_size  in  2`: 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- `req_unsigned  in  1`: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr  in  13`: byte address; any alignment is legal.
- `req_wdata  in  32`: store data, LSB-aligned.
- `rsp_valid  out  1`: response available.
- `rsp_ready  in  1`: response consumed.
- `rsp_rdata  out  32`: load data; 0 for stores.
- `rsp_err  out  1`: wrap error (see Configuration).
- `mem_ena, mem_wea  out  1`: RAM port A enable and write enable.
- `mem_addra  out  13`, `mem_dina  out  32`: RAM port A address and write data.
- `mem_rstb  out  1`: equals `~rst_n`.
- `mem_enb  out  1`, `mem_addrb  out  13`: RAM port B enable and address.
- `mem_doutb  in  32`: RAM read data, valid one cycle after `mem_enb`.

## Operation
- States: IDLE, RD, CAP, WR, RSP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch we/size/unsigned/addr/wdata.
  - Next state: word store → WR; load or sub-word store → RD.
- RD:
  - `mem_enb` = 1, `mem_addrb` = latched address.
  - Next state: CAP.
- CAP:
  - `mem_addrb` is held at the same address, because the RAM lane rotation depends on the address live during this cycle. `mem_enb` = 0.
  - Load: capture `mem_doutb` and format it. Byte: bits [7:0], extended from bit 7. Half: bits [15:0], extended from bit 15. Word: as read. Next state: RSP.
  - Sub-word store: merge value = `mem_doutb` with [7:0] (byte) or [15:0] (half) replaced from `req_wdata`. Next state: WR.
- WR:
  - `mem_ena` = `mem_wea` = 1, `mem_addra` = latched address.
  - `mem_dina` = merge value, or `req_wdata` for word stores.
  - Next state: RSP.
- RSP:
  - `rsp_valid` = 1; `rsp_rdata` and `rsp_err` stay stable.
  - On `rsp_ready`, next state: IDLE.
- At most one access is outstanding. A `req_valid` outside IDLE is ignored; the requester holds it.
- Address arithmetic is modulo 8192. An access at 0x1FFF+k touches bytes 0x1FFF, 0x0000, … in order.
- All memory-side outputs are registered or decoded from state. No combinational path runs from `req_*` to `mem_*`.

## Timing
- Reset values:
  - State IDLE, so `req_ready` = 1.
  - `rsp_valid`, `rsp_err`, `mem_ena`, `mem_wea`, `mem_enb` = 0.
  - `rsp_rdata`, `mem_addra`, `mem_addrb`, `mem_dina` = 0.
  - `mem_rstb` = 1 while `rst_n` = 0.
- Latency, counted from the accepting edge to `rsp_valid` high:
  - Load: 3 edges.
  - Word store: 2 edges.
  - Sub-word store: 4 edges.
- Throughput: the next request is accepted on the edge after the `rsp_ready` handshake edge, giving one idle cycle minimum.
- `rsp_ready` may be held high permanently. `rsp_valid` then pulses for one cycle.
- Reset asserted mid-access aborts it immediately. If reset hits during WR, the write may or may not complete. No response is produced after reset.

## Configuration
- `LSU_WRAP_ERR_EN`
  - Defined: an access whose last byte crosses 0x1FFF→0x0000 is not performed. The block goes IDLE→RSP with `rsp_err` = 1 and `rsp_rdata` = 0. Latency is 1 edge.
  - Undefined: `rsp_err` is tied to 0 and accesses wrap.

## Test plan
- Word store 0xA1B2C3D4 to 0x0005, then word load from 0x0005 → `rsp_rdata` = 0xA1B2C3D4, 3-edge latency. Word load from 0x0004 → low byte 0x00 (initial) and upper bytes 0xB2C3D4.
- Byte store 0x80 to 0x0006 over the previous data, then signed byte load → 0xFFFFFF80. Unsigned → 0x00000080. Word load from 0x0005 → 0xA1B280D4.
- Half store 0x1234 to 0x0003, then signed half load → 0x00001234. Bytes 0x0005/0x0006 must be unchanged (RMW check via `mem_*` monitor: exactly one RD then one WR).
- Word store 0x11223344 to 0x1FFE. With the macro undefined, a word load at 0x1FFE returns 0x11223344 and bytes 0x0000/0x0001 equal 0x22/0x11. With it defined, `rsp_err` = 1 and no `mem_ena`.
- `rsp_ready` held low for 5 cycles in RSP → `rsp_valid` and data stable, `req_ready` = 0, and an extra `req_valid` is ignored. Then `rsp_ready` goes high → IDLE next edge.
- `rst_n` pulsed low during CAP of a load → all outputs at reset values asynchronously, and no `rsp_valid` follows.

Source files
------------

// File: rtl/ram_lsu.sv
// Load/store sequencer driving the byte-lane ram: one access at a time, sub-word stores by read-modify-write.
// Optional LSU_WRAP_ERR_EN: reject accesses whose last byte wraps past 0x1FFF with rsp_err instead of wrapping.
module ram_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [12:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_ena,
  output logic        mem_wea,
  output logic [12:0] mem_addra,
  output logic [31:0] mem_dina,
  output logic        mem_rstb,
  output logic        mem_enb,
  output logic [12:0] mem_addrb,
  input  logic [31:0] mem_doutb
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RSP  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [12:0] addr_q, addr_d;
  logic [31:0] dina_q, dina_d;
  logic [31:0] rdata_q, rdata_d;

  function automatic logic [31:0] fmt_load(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
    case (size)
      2'd0:    return {{24{~uns & raw[7]}}, raw[7:0]};
      2'd1:    return {{16{~uns & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] raw, input logic [31:0] wdata,
                                              input logic [1:0] size);
    case (size)
      2'd0:    return {raw[31:8], wdata[7:0]};
      2'd1:    return {raw[31:16], wdata[15:0]};
      default: return wdata;
    endcase
  endfunction

`ifdef LSU_WRAP_ERR_EN
  logic        err_q, err_d;
  logic [2:0]  nbytes_s;
  logic        wrap_s;

  // Access wraps when its last byte lies beyond 0x1FFF.
  always_comb begin
    case (req_size)
      2'd0:    nbytes_s = 3'd1;
      2'd1:    nbytes_s = 3'd2;
      default: nbytes_s = 3'd4;
    endcase
    wrap_s = ({1'b0, req_addr} + {11'd0, nbytes_s}) > 14'd8192;
  end
`endif

  // Next-state and datapath register inputs.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    dina_d  = dina_q;
    rdata_d = rdata_q;
`ifdef LSU_WRAP_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          dina_d  = req_wdata;
          rdata_d = 32'd0;
`ifdef LSU_WRAP_ERR_EN
          err_d   = wrap_s;
          if (wrap_s) begin
            state_d = S_RSP;
          end else if (req_we && req_size[1]) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
`else
          if (req_we && req_size[1]) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD:  state_d = S_CAP;
      // dina_q still holds the store data here, so it doubles as the merge source.
      S_CAP: begin
        if (we_q) begin
          dina_d  = merge_store(mem_doutb, dina_q, size_q);
          state_d = S_WR;
        end else begin
          rdata_d = fmt_load(mem_doutb, size_q, uns_q);
          state_d = S_RSP;
        end
      end
      S_WR:  state_d = S_RSP;
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RSP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= 13'd0;
      dina_q  <= 32'd0;
      rdata_q <= 32'd0;
`ifdef LSU_WRAP_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      dina_q  <= dina_d;
      rdata_q <= rdata_d;
`ifdef LSU_WRAP_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_rdata = rdata_q;
`ifdef LSU_WRAP_ERR_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif
  assign mem_ena   = (state_q == S_WR);
  assign mem_wea   = (state_q == S_WR);
  assign mem_addra = addr_q;
  assign mem_dina  = dina_q;
  assign mem_enb   = (state_q == S_RD);
  assign mem_addrb = addr_q;
  assign mem_rstb  = ~rst_n;

endmodule

// File: tb/tb_ram_lsu.sv
// Self-checking bench for ram_lsu: banked byte-lane RAM model plus a byte-array reference of memory contents.
module tb_ram_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_ena, mem_wea, mem_rstb, mem_enb;
  logic [12:0] mem_addra, mem_addrb;
  logic [31:0] mem_dina, mem_doutb;

  int n_checks = 0;
  int n_errors = 0;

  ram_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
    .mem_rstb(mem_rstb), .mem_enb(mem_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
  );

  always #5 clk = ~clk;

  // RAM model: four byte banks, registered bank reads, output lanes rotated by the live read address.
  logic [7:0] ram     [8192];
  logic [7:0] ref_mem [8192];
  logic [7:0] rd_bank [4];

  always @(posedge clk) begin
    if (mem_ena && mem_wea)
      for (int k = 0; k < 4; k++) ram[mem_addra + 13'(k)] <= mem_dina[8*k +: 8];
    if (mem_enb)
      for (int b = 0; b < 4; b++)
        rd_bank[b] <= ram[mem_addrb + 13'((b - int'(mem_addrb[1:0])) & 3)];
  end

  always_comb begin
    mem_doutb = 32'd0;
    for (int k = 0; k < 4; k++) mem_doutb[8*k +: 8] = rd_bank[2'(mem_addrb[1:0] + 2'(k))];
  end

  // Port activity monitor.
  int          n_rd = 0, n_wr = 0;
  logic [12:0] last_addra = 13'd0, last_addrb = 13'd0;
  always @(posedge clk) begin
    if (mem_enb) begin
      n_rd       <= n_rd + 1;
      last_addrb <= mem_addrb;
    end
    if (mem_ena && mem_wea) begin
      n_wr       <= n_wr + 1;
      last_addra <= mem_addra;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [12:0] addr, input logic [1:0] size,
                                           input logic uns);
    int nb = size_bytes(size);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[(int'(addr) + k) % 8192];
    if (!uns && nb < 4 && v[8*nb-1])
      for (int i = 8 * nb; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata,      32'd0);
    check_eq({tag, "_mem_ena"},   32'(mem_ena),   32'd0);
    check_eq({tag, "_mem_wea"},   32'(mem_wea),   32'd0);
    check_eq({tag, "_mem_enb"},   32'(mem_enb),   32'd0);
    check_eq({tag, "_mem_addra"}, 32'(mem_addra), 32'd0);
    check_eq({tag, "_mem_addrb"}, 32'(mem_addrb), 32'd0);
    check_eq({tag, "_mem_dina"},  mem_dina,       32'd0);
    check_eq({tag, "_mem_rstb"},  32'(mem_rstb),  32'd1);
  endtask

  // One complete access; called with the DUT idle and inputs driven at the negedge.
  task automatic run_access(input string tag, input logic we, input logic [1:0] size,
                            input logic uns, input logic [12:0] addr, input logic [31:0] wdata,
                            input int stall, output logic [31:0] rd);
    int nb = size_bytes(size);
    logic exp_err = 1'b0;
    logic [31:0] exp_data;
    int exp_lat, exp_rd, exp_wr, rd0, wr0, lat;
`ifdef LSU_WRAP_ERR_EN
    exp_err = (int'(addr) + nb) > 8192;
`endif
    exp_data = (we || exp_err) ? 32'd0 : ref_load(addr, size, uns);
    exp_lat  = exp_err ? 1 : (!we ? 3 : (nb == 4 ? 2 : 4));
    exp_rd   = (exp_err || (we && nb == 4)) ? 0 : 1;
    exp_wr   = (we && !exp_err) ? 1 : 0;

    @(negedge clk);
    check_eq({tag, "_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; rsp_ready = (stall == 0);
    rd0 = n_rd; wr0 = n_wr;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_rdata"}, rsp_rdata, exp_data);
    check_eq({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rd = rsp_rdata;
    for (int i = 0; i < stall; i++) begin
      if (i == 1) begin
        req_valid = 1'b1; req_we = ~we; req_addr = addr ^ 13'h0100; req_size = 2'd2;
      end
      @(negedge clk);
      check_eq({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
      check_eq({tag, "_stall_rdata"}, rsp_rdata, exp_data);
      check_eq({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_back_idle"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_n_rd"}, 32'(n_rd - rd0), 32'(exp_rd));
    check_eq({tag, "_n_wr"}, 32'(n_wr - wr0), 32'(exp_wr));
    if (n_rd != rd0) check_eq({tag, "_addrb"}, 32'(last_addrb), 32'(addr));
    if (n_wr != wr0) check_eq({tag, "_addra"}, 32'(last_addra), 32'(addr));
    if (we && !exp_err)
      for (int k = 0; k < nb; k++) ref_mem[(int'(addr) + k) % 8192] = wdata[8*k +: 8];
  endtask

  initial begin
    logic [31:0] rd;
    int seen, bad;
    for (int i = 0; i < 8192; i++) begin
      ram[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    for (int b = 0; b < 4; b++) rd_bank[b] = 8'd0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 13'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rstb_released", 32'(mem_rstb), 32'd0);

    run_access("st_w5", 1'b1, 2'd2, 1'b0, 13'h0005, 32'hA1B2C3D4, 0, rd);
    run_access("ld_w5", 1'b0, 2'd2, 1'b0, 13'h0005, 32'd0, 0, rd);
    check_eq("plan_ld_w5", rd, 32'hA1B2C3D4);
    run_access("ld_w4", 1'b0, 2'd2, 1'b0, 13'h0004, 32'd0, 0, rd);
    check_eq("plan_ld_w4", rd, 32'hB2C3D400);
    run_access("st_b6", 1'b1, 2'd0, 1'b0, 13'h0006, 32'hFFFF_FF80, 0, rd);
    run_access("ld_bs6", 1'b0, 2'd0, 1'b0, 13'h0006, 32'd0, 0, rd);
    check_eq("plan_ld_bs6", rd, 32'hFFFFFF80);
    run_access("ld_bu6", 1'b0, 2'd0, 1'b1, 13'h0006, 32'd0, 0, rd);
    check_eq("plan_ld_bu6", rd, 32'h00000080);
    run_access("ld_w5b", 1'b0, 2'd2, 1'b0, 13'h0005, 32'd0, 0, rd);
    check_eq("plan_ld_w5b", rd, 32'hA1B280D4);
    run_access("st_h3", 1'b1, 2'd1, 1'b0, 13'h0003, 32'h5555_1234, 0, rd);
    run_access("ld_hs3", 1'b0, 2'd1, 1'b0, 13'h0003, 32'd0, 0, rd);
    check_eq("plan_ld_hs3", rd, 32'h00001234);
    run_access("ld_b5", 1'b0, 2'd0, 1'b1, 13'h0005, 32'd0, 0, rd);
    check_eq("plan_ld_b5", rd, 32'h000000D4);
    run_access("st_wrap", 1'b1, 2'd2, 1'b0, 13'h1FFE, 32'h11223344, 0, rd);
    run_access("ld_wrap", 1'b0, 2'd2, 1'b0, 13'h1FFE, 32'd0, 0, rd);
`ifdef LSU_WRAP_ERR_EN
    check_eq("plan_ld_wrap", rd, 32'h00000000);
`else
    check_eq("plan_ld_wrap", rd, 32'h11223344);
    run_access("ld_b0", 1'b0, 2'd0, 1'b1, 13'h0000, 32'd0, 0, rd);
    check_eq("plan_ld_b0", rd, 32'h00000022);
    run_access("ld_b1", 1'b0, 2'd0, 1'b1, 13'h0001, 32'd0, 0, rd);
    check_eq("plan_ld_b1", rd, 32'h00000011);
`endif
    run_access("stall_ld", 1'b0, 2'd2, 1'b0, 13'h0005, 32'd0, 5, rd);

    for (int n = 0; n < 80; n++) begin
      logic [12:0] a;
      a = ($urandom_range(0, 3) == 0) ? 13'(8192 - $urandom_range(1, 4))
                                      : 13'($urandom_range(0, 63));
      run_access("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), rd);
    end

    // Reset while the load sits in CAP.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 13'h0005; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check_eq("no_rsp_after_reset", 32'(seen), 32'd0);

    bad = 0;
    for (int i = 0; i < 8192; i++) if (ram[i] !== ref_mem[i]) bad++;
    check_eq("mem_image", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
